// File: rtl/price_predictor.sv
// Predicts y_hat = B0 + B1*x with a W-cycle shift-add multiplier and Q10.10 saturation.
// Optional absolute-error accumulator enabled by defining PREDICT_ERR_EN.
module price_predictor #(
  parameter int W    = 20,
  parameter int FRAC = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           coef_load,
  input  logic [W-1:0]   b0_in,
  input  logic [W-1:0]   b1_in,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y_ref,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   y_hat,
  output logic           sat,
  output logic [2*W-1:0] err_sum,
  output logic [W-1:0]   err_cnt
);

  localparam int CW = $clog2(W);

  if (FRAC >= W) begin : g_bad_frac
    $error("FRAC must be smaller than W");
  end

  typedef enum logic [1:0] {IDLE, MUL, SUM, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   b0_q, b1_q, x_q;
  logic [2*W:0]   mcand, acc, r;
  logic [CW-1:0]  cnt;
  logic           accept, load_ok, hs, sat_hi, sat_lo;

  assign accept  = in_valid & in_ready;
  assign load_ok = (state == IDLE) & coef_load;
  assign hs      = (state == DONE) & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = MUL;
      MUL:  if (cnt == CW'(W-1)) state_nx = SUM;
      SUM:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) & ~coef_load;
  end

  // Overflow when the bits above the Q10.10 sign bit disagree with the sign.
  assign r      = acc + {{(W+1){b0_q[W-1]}}, b0_q};
  assign sat_hi = ~r[2*W] & (|r[2*W-1:W-1]);
  assign sat_lo =  r[2*W] & ~(&r[2*W-1:W-1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b0_q      <= '0;
      b1_q      <= '0;
      x_q       <= '0;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      y_hat     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_ok) begin
            b0_q <= b0_in;
            b1_q <= b1_in;
          end else if (accept) begin
            x_q   <= x;
            mcand <= {{(W+1){b1_q[W-1]}}, b1_q};
            acc   <= '0;
            cnt   <= '0;
          end
        end
        MUL: begin
          if (x_q[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          x_q   <= x_q >> 1;
          cnt   <= cnt + 1'b1;
        end
        SUM: begin
          if (sat_hi) begin
            y_hat <= {1'b0, {(W-1){1'b1}}};
            sat   <= 1'b1;
          end else if (sat_lo) begin
            y_hat <= {1'b1, {(W-1){1'b0}}};
            sat   <= 1'b1;
          end else begin
            y_hat <= r[W-1:0];
            sat   <= 1'b0;
          end
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef PREDICT_ERR_EN
  logic [W-1:0]   yref_q;
  logic [W:0]     diff, adiff;
  logic [2*W:0]   esum_nx;

  assign diff    = {y_hat[W-1], y_hat} - {yref_q[W-1], yref_q};
  assign adiff   = diff[W] ? -diff : diff;
  assign esum_nx = {1'b0, err_sum} + {{(W-1){1'b0}}, adiff};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      yref_q  <= '0;
      err_sum <= '0;
      err_cnt <= '0;
    end else if (load_ok) begin
      err_sum <= '0;
      err_cnt <= '0;
    end else begin
      if (accept) yref_q <= y_ref;
      if (hs) begin
        err_sum <= esum_nx[2*W] ? '1 : esum_nx[2*W-1:0];
        if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_yref;
  assign unused_yref = ^{y_ref, hs};
  assign err_sum     = '0;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_price_predictor.sv
// Directed self-checking bench for price_predictor with hand-computed expectations.
module tb_price_predictor;
  localparam int W = 20;

  logic           clk = 1'b0;
  logic           reset;
  logic           coef_load;
  logic [W-1:0]   b0_in, b1_in;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x, y_ref;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   y_hat;
  logic           sat;
  logic [2*W-1:0] err_sum;
  logic [W-1:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  price_predictor #(.W(W), .FRAC(10)) dut (
    .clk(clk), .reset(reset), .coef_load(coef_load), .b0_in(b0_in), .b1_in(b1_in),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y_ref(y_ref),
    .out_valid(out_valid), .out_ready(out_ready), .y_hat(y_hat), .sat(sat),
    .err_sum(err_sum), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] b0, input logic [W-1:0] b1, input bit probe);
    coef_load = 1'b1;
    b0_in     = b0;
    b1_in     = b1;
    in_valid  = probe;
    x         = 20'd3;
    #1;
    chk("load_blocks_ready", in_ready, 0);
    tick();
    coef_load = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk("idle_after_load", in_ready, 1);
  endtask

  task automatic predict(input logic [W-1:0] xv, input logic [W-1:0] yr,
                         input logic [W-1:0] ey, input logic es,
                         input int hold, input bit ld_pulse);
    int lat;
    bit rdy_seen;
    in_valid = 1'b1;
    x        = xv;
    y_ref    = yr;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    rdy_seen = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
      if (in_ready) rdy_seen = 1;
    end
    chk("latency", lat, 21);
    chk("y_hat", y_hat, ey);
    chk("sat", sat, es);
    chk("in_ready_busy", rdy_seen, 0);
    for (int i = 0; i < hold; i++) begin
      coef_load = ld_pulse && (i == 0);
      b0_in     = '0;
      b1_in     = '0;
      tick();
      coef_load = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_y_hat", y_hat, ey);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid_low", out_valid, 0);
    chk("hs_y_hat_kept", y_hat, ey);
  endtask

  initial begin
    logic [2*W-1:0] exp_sum;
    logic [W-1:0]   exp_cnt;
    reset     = 1'b0;
    coef_load = 1'b0;
    b0_in     = '0;
    b1_in     = '0;
    in_valid  = 1'b0;
    x         = '0;
    y_ref     = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y_hat", y_hat, 0);
    chk("rst_sat", sat, 0);
    chk("rst_err_sum", err_sum, 0);
    chk("rst_err_cnt", err_cnt, 0);
    reset = 1'b1;
    tick();

    load(20'h00800, 20'h00600, 0);
    predict(20'd10, 20'h0, 20'h04400, 0, 0, 0);

    load(20'hFFC00, 20'h00100, 0);
    predict(20'd4, 20'h0, 20'h00000, 0, 0, 0);
    predict(20'd0, 20'h0, 20'hFFC00, 0, 0, 0);

    load(20'h00000, 20'h19000, 0);
    predict(20'd10, 20'h0, 20'h7FFFF, 1, 0, 0);
    load(20'h00000, 20'hE7000, 0);
    predict(20'd10, 20'h0, 20'h80000, 1, 0, 0);

    load(20'h00123, 20'h00000, 0);
    predict(20'hFFFFF, 20'h0, 20'h00123, 0, 0, 0);

    load(20'h00800, 20'h00600, 0);
    predict(20'd10, 20'h0, 20'h04400, 0, 5, 1);
    predict(20'd2, 20'h0, 20'h01400, 0, 0, 0);

    in_valid = 1'b1;
    x        = 20'd5;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_y_hat", y_hat, 0);
    reset = 1'b1;
    tick();
    predict(20'd7, 20'h0, 20'h00000, 0, 0, 0);

    load(20'h00800, 20'h00600, 1);
    predict(20'd10, 20'h04000, 20'h04400, 0, 0, 0);
    predict(20'd2, 20'h01800, 20'h01400, 0, 0, 0);
`ifdef PREDICT_ERR_EN
    exp_sum = 40'h00800;
    exp_cnt = 20'd2;
`else
    exp_sum = '0;
    exp_cnt = '0;
`endif
    chk("err_sum", err_sum, exp_sum);
    chk("err_cnt", err_cnt, exp_cnt);
    load(20'h00800, 20'h00600, 0);
    chk("err_sum_clr", err_sum, 0);
    chk("err_cnt_clr", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
